div: RTL and testbench

//  Sequential signed 32-bit divider for the CPU's DIV instruction; it is the inverse of the

---
 rtl/div_if.sv | 23 ++
 rtl/div.sv | 98 +++++++++
 tb/tb_div.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Operand/result bundle between the control unit and the divider.
// The control unit drives the master side; the divider is the slave.
interface div_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             divControl;
    logic             divStop;
    logic             divZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, divControl,
        input  divStop, divZero, hi, lo
    );

    modport slave (
        input  a, b, divControl,
        output divStop, divZero, hi, lo
    );
endinterface

// File: rtl/div.sv
// Sequential signed divider: one restoring quotient bit per clock.
// Quotient goes to lo, remainder to hi; divide-by-zero is flagged.
module div #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  Reset,
    div_if.slave  io
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        ZERO
    } state_t;

    state_t           state, state_n;
    logic [WIDTH:0]   rem, rem_sh;
    logic [WIDTH-1:0] quo, absb;
    logic [WIDTH-1:0] abs_a_in, abs_b_in;
    logic             sign_q, sign_r;
    logic [CW-1:0]    count;
    logic             ge;

    // Magnitudes stay WIDTH-bit unsigned, so the most negative value maps to itself.
    always_comb begin
        abs_a_in = io.a[WIDTH-1] ? -io.a : io.a;
        abs_b_in = io.b[WIDTH-1] ? -io.b : io.b;
        rem_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        ge       = rem_sh >= {1'b0, absb};
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: state_n = IDLE;
            RUN:  if (count == CW'(1)) state_n = FIX;
            FIX:  state_n = IDLE;
            ZERO: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (io.divControl)
            state_n = (io.b == '0) ? ZERO : RUN;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rem        <= '0;
            quo        <= '0;
            absb       <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            count      <= '0;
            io.divStop <= 1'b0;
            io.divZero <= 1'b0;
            io.hi      <= '0;
            io.lo      <= '0;
        end else begin
            io.divStop <= 1'b0;
            if (io.divControl) begin
                // A start always wins, aborting any op in flight.
                sign_q     <= io.a[WIDTH-1] ^ io.b[WIDTH-1];
                sign_r     <= io.a[WIDTH-1];
                rem        <= '0;
                quo        <= abs_a_in;
                absb       <= abs_b_in;
                count      <= CW'(WIDTH);
                io.divZero <= 1'b0;
            end else begin
                unique case (state)
                    RUN: begin
                        rem   <= ge ? rem_sh - {1'b0, absb} : rem_sh;
                        quo   <= {quo[WIDTH-2:0], ge};
                        count <= count - CW'(1);
                    end
                    FIX: begin
                        io.lo      <= sign_q ? -quo : quo;
                        io.hi      <= sign_r ? -rem[WIDTH-1:0]
                                             : rem[WIDTH-1:0];
                        io.divStop <= 1'b1;
                    end
                    ZERO: begin
                        io.divStop <= 1'b1;
                        io.divZero <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div.sv
// Directed and random checks of the divider against a signed-arithmetic model.
// Results are compared at negedges, half a cycle after the state changes.
module tb_div;
    logic clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_lo = '0;
    logic [31:0] exp_hi = '0;

    div_if #(.WIDTH(32)) bus ();

    div #(.WIDTH(32)) dut (
        .clk   (clk),
        .Reset (Reset),
        .io    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Truncating signed division; remainder follows the dividend.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = 32'(sa / sb);
        r = 32'(sa % sb);
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.divControl = 1'b1;
        @(posedge clk);
        #1 bus.divControl = 1'b0;
    endtask

    // Watches 41 cycles after the start edge for exactly one divStop.
    task automatic await_done(input string tag, input int lat,
                              input logic zero);
        int first, highs;
        first = -1;
        highs = 0;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (bus.divStop === 1'b1) begin
                highs++;
                if (first < 0) first = i;
            end
        end
        chk({tag, ".lat"}, 32'(first), 32'(lat));
        chk({tag, ".pulses"}, 32'(highs), 32'd1);
        chk({tag, ".lo"}, bus.lo, exp_lo);
        chk({tag, ".hi"}, bus.hi, exp_hi);
        chk({tag, ".zero"}, {31'd0, bus.divZero}, {31'd0, zero});
    endtask

    task automatic op(input string tag, input logic [31:0] a,
                      input logic [31:0] b);
        if (b != '0) model(a, b, exp_lo, exp_hi);
        launch(a, b);
        await_done(tag, (b == '0) ? 1 : 33, b == '0);
    endtask

    initial begin
        int stray;
        logic [31:0] ra, rb;
        Reset = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.divControl = 1'b0;
        #12;
        chk("rst.lo", bus.lo, 32'd0);
        chk("rst.hi", bus.hi, 32'd0);
        chk("rst.stop", {31'd0, bus.divStop}, 32'd0);
        chk("rst.zero", {31'd0, bus.divZero}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;

        op("t1", 32'd7, 32'd2);
        op("t2a", 32'hFFFF_FFF9, 32'd2);
        op("t2b", 32'd7, 32'hFFFF_FFFE);

        op("t3z", 32'h1234_5678, 32'd0);
        launch(32'd11, 32'd1);
        @(negedge clk);
        chk("t3.clr", {31'd0, bus.divZero}, 32'd0);
        exp_lo = 32'd11;
        exp_hi = 32'd0;
        await_done("t3b", 32, 1'b0);

        exp_lo = 32'h8000_0000;
        exp_hi = 32'd0;
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        await_done("t4ovf", 33, 1'b0);
        op("t4b", 32'd5, 32'd9);
        op("t4c", 32'h8000_0000, 32'd1);

        stray = 0;
        launch(32'd100, 32'd7);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus.divStop === 1'b1) stray++;
        end
        exp_lo = 32'd3;
        exp_hi = 32'd0;
        launch(32'd9, 32'd3);
        await_done("t5", 33, 1'b0);
        chk("t5.stray", 32'(stray), 32'd0);

        launch(32'd1000, 32'd3);
        for (int i = 0; i < 14; i++) @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("t6.lo", bus.lo, 32'd0);
        chk("t6.hi", bus.hi, 32'd0);
        chk("t6.stop", {31'd0, bus.divStop}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.divStop === 1'b1) stray++;
        end
        chk("t6.nostop", 32'(stray), 32'd0);
        chk("t6.hold", bus.lo, 32'd0);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 3 == 0) rb = 32'($signed(rb) >>> $urandom_range(30, 8));
            if (n % 4 == 1) ra = 32'($signed(ra) >>> $urandom_range(24, 4));
            if (rb == '0) rb = 32'd13;
            op($sformatf("rnd%0d", n), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
